// File: rtl/data_mem_hs.sv
// Handshaked MEM-stage data memory: one request at a time, WAIT_STATES stall, one response.
// Optional feature macro: DMEM_ALIGN_CHK_EN (misaligned / out-of-range fault reporting).
module data_mem_hs #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned AW          = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [2:0]    req_func3,
   input  logic [AW-1:0] req_addr,
   input  logic [31:0]   req_wdata,
   output logic          rsp_valid,
   output logic [31:0]   rsp_rdata,
   output logic          rsp_err
);

   localparam int unsigned IW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT =
      (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_e;

   state_e        state_q;
   logic [3:0]    cnt_q;
   logic          we_q;
   logic [2:0]    func3_q;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;
   logic          rsp_valid_q;
   logic [31:0]   rdata_q;
   logic          err_q;

   logic [31:0]   mem_q [DEPTH_WORDS];

   logic          accept;
   logic          go_resp;
   logic          commit;
   logic          op_we;
   logic [2:0]    op_f3;
   logic [AW-1:0] op_addr;
   logic [31:0]   op_wdata;
   logic          is_h;
   logic          is_w;
   logic [AW-1:0] hi;
   logic [IW-1:0] idx;
   logic [1:0]    off;
   logic          err_d;
   logic [31:0]   rd_word;
   logic [31:0]   sh;
   logic [31:0]   ld;
   logic [31:0]   rdata_d;
   logic [31:0]   wd_sh;
   logic [3:0]    be;

   assign req_ready = (state_q == S_IDLE) && rst_n;
   assign accept    = req_valid && req_ready;
   assign go_resp   = (WAIT_STATES == 0) ? accept
                    : (state_q == S_WAIT && cnt_q == 4'd0);

   // With no wait states the access executes on the accept edge itself.
   always_comb begin
      op_we    = we_q;
      op_f3    = func3_q;
      op_addr  = addr_q;
      op_wdata = wdata_q;
      if (state_q == S_IDLE) begin
         op_we    = req_we;
         op_f3    = req_func3;
         op_addr  = req_addr;
         op_wdata = req_wdata;
      end
   end

   assign is_h = (op_f3[1:0] == 2'b01);
   assign is_w = op_f3[1];
   assign hi   = op_addr >> (IW + 2);
   assign idx  = op_addr[IW+1:2];

`ifdef DMEM_ALIGN_CHK_EN
   assign off   = op_addr[1:0];
   assign err_d = (is_h & op_addr[0]) | (is_w & (|op_addr[1:0])) | (|hi);
`else
   logic unused_hi;
   assign off = is_w ? 2'b00
              : (is_h ? {op_addr[1], 1'b0} : op_addr[1:0]);
   assign err_d     = 1'b0;
   assign unused_hi = |hi;
`endif

   always_comb begin
      rd_word = mem_q[idx];
      sh      = rd_word >> {off, 3'b000};
      case (op_f3)
         3'b000:  ld = {{24{sh[7]}}, sh[7:0]};
         3'b001:  ld = {{16{sh[15]}}, sh[15:0]};
         3'b100:  ld = {24'h0, sh[7:0]};
         3'b101:  ld = {16'h0, sh[15:0]};
         default: ld = sh;
      endcase
      rdata_d = (op_we | err_d) ? 32'h0 : ld;
   end

   always_comb begin
      wd_sh = op_wdata << {off, 3'b000};
      unique case (1'b1)
         is_w:    be = 4'b1111;
         is_h:    be = 4'b0011 << off;
         default: be = 4'b0001 << off;
      endcase
   end

   assign commit = go_resp & op_we & ~err_d;

   always_ff @(posedge clk) begin
      if (commit) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem_q[idx][8*i +: 8] <= wd_sh[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         we_q        <= 1'b0;
         func3_q     <= 3'b000;
         addr_q      <= '0;
         wdata_q     <= 32'h0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= 32'h0;
         err_q       <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         if (go_resp) begin
            rsp_valid_q <= 1'b1;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
         end
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  we_q    <= req_we;
                  func3_q <= req_func3;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  cnt_q   <= CNT_INIT;
                  state_q <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt_q == 4'd0) state_q <= S_RESP;
               else               cnt_q   <= cnt_q - 4'd1;
            end
            S_RESP:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_hs.sv
// Directed bench for data_mem_hs: WAIT_STATES=2 and WAIT_STATES=0 instances.
// Expectations follow DMEM_ALIGN_CHK_EN when it is defined for the build.
module tb_data_mem_hs;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        a_valid = 1'b0, a_ready, a_we = 1'b0;
   logic [2:0]  a_f3 = 3'b000;
   logic [31:0] a_addr = 32'h0, a_wd = 32'h0;
   logic        a_rv, a_err;
   logic [31:0] a_rd;

   logic        b_valid = 1'b0, b_ready, b_we = 1'b0;
   logic [2:0]  b_f3 = 3'b000;
   logic [31:0] b_addr = 32'h0, b_wd = 32'h0;
   logic        b_rv, b_err;
   logic [31:0] b_rd;

   int n_chk = 0;
   int n_fail = 0;

   localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010;
   localparam logic [2:0] F_BU = 3'b100, F_HU = 3'b101;

   always #5 clk = ~clk;

   data_mem_hs #(.DEPTH_WORDS(1024), .WAIT_STATES(2), .AW(32)) u_a (
      .clk(clk), .rst_n(rst_n),
      .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
      .req_func3(a_f3), .req_addr(a_addr), .req_wdata(a_wd),
      .rsp_valid(a_rv), .rsp_rdata(a_rd), .rsp_err(a_err)
   );

   data_mem_hs #(.DEPTH_WORDS(16), .WAIT_STATES(0), .AW(32)) u_b (
      .clk(clk), .rst_n(rst_n),
      .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
      .req_func3(b_f3), .req_addr(b_addr), .req_wdata(b_wd),
      .rsp_valid(b_rv), .rsp_rdata(b_rd), .rsp_err(b_err)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // One request on instance sel (0=A, 1=B); reports response and timing.
   task automatic xact(input bit sel, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er,
                       output int lat, output int low);
      bit got = 0;
      rd = 32'h0; er = 1'b0; lat = -1; low = 0;
      @(negedge clk);
      if (sel) begin
         b_valid = 1; b_we = we; b_f3 = f3; b_addr = addr; b_wd = wd;
      end else begin
         a_valid = 1; a_we = we; a_f3 = f3; a_addr = addr; a_wd = wd;
      end
      for (int k = 0; k < 20; k++) begin
         if (sel ? b_ready : a_ready) break;
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      a_valid = 0;
      b_valid = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if ((sel ? b_rv : a_rv) && !got) begin
            got = 1;
            lat = k;
            rd = sel ? b_rd : a_rd;
            er = sel ? b_err : a_err;
         end
         if (sel ? b_ready : a_ready) break;
         low++;
      end
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat, low, pulses;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_valid", 32'(a_rv), 32'h0);
      chk("rst_rdata", a_rd, 32'h0);
      chk("rst_err", 32'(a_err), 32'h0);
      chk("rst_ready", 32'(a_ready), 32'h1);

      xact(0, 1, F_W, 32'h10, 32'hDEAD_BEEF, rd, er, lat, low);
      chk("sw_lat", 32'(lat), 32'd3);
      chk("sw_low", 32'(low), 32'd3);
      chk("sw_err", 32'(er), 32'h0);
      chk("sw_rdata", rd, 32'h0);

      xact(0, 0, F_B, 32'h11, 32'h0, rd, er, lat, low);
      chk("lb", rd, 32'hFFFF_FFBE);
      xact(0, 0, F_BU, 32'h11, 32'h0, rd, er, lat, low);
      chk("lbu", rd, 32'h0000_00BE);
      xact(0, 0, F_H, 32'h12, 32'h0, rd, er, lat, low);
      chk("lh", rd, 32'hFFFF_DEAD);
      xact(0, 0, F_HU, 32'h12, 32'h0, rd, er, lat, low);
      chk("lhu", rd, 32'h0000_DEAD);
      chk("lhu_lat", 32'(lat), 32'd3);

      xact(0, 1, F_B, 32'h13, 32'h0000_0055, rd, er, lat, low);
      xact(0, 0, F_W, 32'h10, 32'h0, rd, er, lat, low);
      chk("sb_lw", rd, 32'h55AD_BEEF);

`ifdef DMEM_ALIGN_CHK_EN
      xact(0, 0, F_W, 32'h11, 32'h0, rd, er, lat, low);
      chk("mis_lw_err", 32'(er), 32'h1);
      chk("mis_lw_rd", rd, 32'h0);
      chk("mis_lw_lat", 32'(lat), 32'd3);
      xact(0, 1, F_W, 32'h12, 32'h1234_5678, rd, er, lat, low);
      chk("mis_sw_err", 32'(er), 32'h1);
      xact(0, 0, F_W, 32'h10, 32'h0, rd, er, lat, low);
      chk("mis_sw_keep", rd, 32'h55AD_BEEF);
      xact(0, 0, F_W, 32'h1000, 32'h0, rd, er, lat, low);
      chk("oor_err", 32'(er), 32'h1);
      chk("oor_rd", rd, 32'h0);
`else
      xact(0, 0, F_W, 32'h11, 32'h0, rd, er, lat, low);
      chk("mis_lw_rd", rd, 32'h55AD_BEEF);
      chk("mis_lw_err", 32'(er), 32'h0);
      xact(0, 0, F_H, 32'h13, 32'h0, rd, er, lat, low);
      chk("mis_lh_rd", rd, 32'h0000_55AD);
      xact(0, 1, F_W, 32'h1000, 32'hA5A5_A5A5, rd, er, lat, low);
      xact(0, 0, F_W, 32'h0, 32'h0, rd, er, lat, low);
      chk("alias_lw", rd, 32'hA5A5_A5A5);
`endif

      // Reset while a store waits: nothing commits, no response.
      @(negedge clk);
      a_valid = 1; a_we = 1; a_f3 = F_W; a_addr = 32'h10; a_wd = 32'h0BAD_F00D;
      @(posedge clk);
      #1 a_valid = 0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rstmid_valid", 32'(a_rv), 32'h0);
      rst_n = 1'b1;
      #1 chk("rstrel_ready", 32'(a_ready), 32'h1);
      pulses = 0;
      repeat (5) begin
         @(negedge clk);
         if (a_rv) pulses++;
      end
      chk("rstmid_norsp", 32'(pulses), 32'h0);
      xact(0, 0, F_W, 32'h10, 32'h0, rd, er, lat, low);
      chk("rstmid_mem", rd, 32'h55AD_BEEF);

      // Zero wait states with req_valid held high.
      @(negedge clk);
      b_valid = 1; b_we = 0; b_f3 = F_W; b_addr = 32'h0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         chk("ws0_pat", 32'({b_ready, b_rv}), (k % 2) ? 32'h1 : 32'h2);
      end
      b_valid = 0;

      xact(1, 1, F_W, 32'h8, 32'h8765_4321, rd, er, lat, low);
      chk("ws0_sw_lat", 32'(lat), 32'd1);
      chk("ws0_sw_low", 32'(low), 32'd1);
      xact(1, 0, F_B, 32'hB, 32'h0, rd, er, lat, low);
      chk("ws0_lb", rd, 32'hFFFF_FF87);
      xact(1, 0, F_HU, 32'hA, 32'h0, rd, er, lat, low);
      chk("ws0_lhu", rd, 32'h0000_8765);
      xact(1, 0, F_H, 32'h8, 32'h0, rd, er, lat, low);
      chk("ws0_lh", rd, 32'h0000_4321);
      chk("ws0_lh_err", 32'(er), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
